prefetch_queue: RTL and testbench

Parametrised instruction prefetch queue for the ARM7TDMI core. It replaces the single-IR fetch path: it issues instruction fetches on the memory bus ahead of execution, buffers up to DEPTH fetched instructions with their addresses, and supports ARM (word) and Thumb (halfword) fetch modes. A pipeline flush on a branch, a PC write or a mode change discards buffered and in-flight fetches and restarts at a new address. It sits between the bus master port and the decoder/control unit.

---
 rtl/prefetch_pkg.sv | 28 ++
 rtl/prefetch_fifo.sv | 66 ++++++
 rtl/prefetch_queue.sv | 166 ++++++++++++++++
 tb/tb_prefetch_queue.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Optional Thumb support in the users of this package is controlled by PREFETCH_THUMB_EN.
package prefetch_pkg;

    typedef logic [31:0] word_t;

    // Fetch FSM states: nothing pending, live request pending, stale request pending
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } prefetch_state_t;

    // One buffered instruction together with the address it was fetched from
    typedef struct packed {
        word_t instr;
        word_t pc;
    } prefetch_entry_t;

    localparam word_t ARM_STEP   = 32'd4;
    localparam word_t THUMB_STEP = 32'd2;

    // Force a fetch address onto the natural alignment of the selected mode
    function automatic word_t align_pc(input word_t pc, input logic thumb);
        return thumb ? {pc[31:1], 1'b0} : {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// DEPTH-entry synchronous FIFO of prefetch entries with clear, count and
// registered-only head outputs (no path from push data to the head).
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  prefetch_entry_t          i_push_entry,
    input  logic                     i_pop,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_valid,
    output prefetch_entry_t          o_head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    prefetch_entry_t r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign w_pop_ok  = i_pop && (r_count != '0);
    // A push into a full FIFO is only legal when the head leaves on the same edge
    assign w_push_ok = i_push && ((r_count != CW'(DEPTH)) || w_pop_ok);

    // Pointer and occupancy bookkeeping; clear overrides any push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end

    // Entry storage; contents need no reset because the head is gated by count
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_clear) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: issues fetches ahead of execution, buffers up to
// DEPTH instructions with their addresses, and restarts on a flush.
// Define PREFETCH_THUMB_EN to enable Thumb (halfword) fetch mode; without it
// every fetch is an ARM word fetch and flush_thumb is ignored.
module prefetch_queue
    import prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        flush_thumb,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_pop,
    output logic        bus_read_en,
    output logic [31:0] bus_addr,
    output logic        bus_instruction_fetch,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int CW = $clog2(DEPTH) + 1;

    prefetch_state_t r_state;
    prefetch_state_t w_state_next;
    word_t           r_fetch_pc;
    word_t           w_fetch_pc_next;
    word_t           r_bus_addr;
    word_t           w_bus_addr_next;
    logic            r_bus_read_en;
    logic            w_read_en_next;

    logic            w_thumb;
    logic            w_thumb_next;
    word_t           w_push_data;
    word_t           w_step;

    logic            w_push;
    logic            w_pop;
    logic            w_issue;
    logic            w_room;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_count_next;

    prefetch_entry_t w_push_entry;
    prefetch_entry_t w_head;

`ifdef PREFETCH_THUMB_EN
    logic  r_thumb;
    logic [15:0] w_halfword;

    assign w_thumb      = r_thumb;
    assign w_thumb_next = flush ? flush_thumb : r_thumb;
    assign w_halfword   = r_bus_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    assign w_push_data  = r_thumb ? {16'h0000, w_halfword} : bus_rdata;

    // Current fetch mode, switched only by a flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_thumb <= 1'b0;
        end else begin
            r_thumb <= w_thumb_next;
        end
    end
`else
    logic w_unused_flush_thumb;

    assign w_unused_flush_thumb = flush_thumb;
    assign w_thumb              = 1'b0;
    assign w_thumb_next         = 1'b0;
    assign w_push_data          = bus_rdata;
`endif

    assign w_step = w_thumb ? THUMB_STEP : ARM_STEP;

    // Only a live (non-stale) request delivers data, and a flush discards it
    assign w_push       = (r_state == REQ) && bus_ack && !flush;
    assign w_pop        = instr_pop && instr_valid && !flush;
    assign w_count_next = flush ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
    assign w_room       = (w_count_next < CW'(DEPTH));

    assign w_push_entry.instr = w_push_data;
    assign w_push_entry.pc    = r_bus_addr;

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (reset),
        .i_clear      (flush),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_valid      (instr_valid),
        .o_head       (w_head)
    );

    // Next fetch address, next state and next bus request
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_issue         = 1'b0;

        if (flush) begin
            w_fetch_pc_next = align_pc(flush_pc, w_thumb_next);
        end else if (w_push) begin
            w_fetch_pc_next = r_fetch_pc + w_step;
        end

        case (r_state)
            IDLE: begin
                w_issue      = w_room;
                w_state_next = w_room ? REQ : IDLE;
            end
            REQ: begin
                if (bus_ack) begin
                    w_issue      = w_room;
                    w_state_next = w_room ? REQ : IDLE;
                end else if (flush) begin
                    w_state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (bus_ack) begin
                    w_issue      = w_room;
                    w_state_next = w_room ? REQ : IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // A request address is always the fetch PC as it stands after this edge
        w_bus_addr_next = w_issue ? w_fetch_pc_next : r_bus_addr;
        w_read_en_next  = (w_state_next != IDLE);
    end

    // State, fetch PC and registered bus request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_fetch_pc    <= RESET_PC;
            r_bus_addr    <= '0;
            r_bus_read_en <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_fetch_pc    <= w_fetch_pc_next;
            r_bus_addr    <= w_bus_addr_next;
            r_bus_read_en <= w_read_en_next;
        end
    end

    assign bus_read_en           = r_bus_read_en;
    assign bus_instruction_fetch = r_bus_read_en;
    assign bus_addr              = r_bus_addr;
    assign instr                 = w_head.instr;
    assign instr_pc              = w_head.pc;

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: a queue-level model predicts the
// bus request and head-of-queue outputs every cycle, plus literal checkpoints.
module tb_prefetch_queue;

    localparam int DEPTH = 4;
`ifdef PREFETCH_THUMB_EN
    localparam bit THUMB_EN = 1'b1;
`else
    localparam bit THUMB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        flush_thumb = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_pop = 1'b0;
    logic        bus_read_en;
    logic [31:0] bus_addr;
    logic        bus_instruction_fetch;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [31:0] mq_instr [$];
    logic [31:0] mq_pc    [$];
    bit          m_pend;
    bit          m_stale;
    logic [31:0] m_addr;
    logic [31:0] m_fpc;
    bit          m_thumb;
    int          ack_lat = 0;
    int          w_cnt   = 0;

    always #5 clk = ~clk;

    prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .flush                 (flush),
        .flush_pc              (flush_pc),
        .flush_thumb           (flush_thumb),
        .instr_valid           (instr_valid),
        .instr                 (instr),
        .instr_pc              (instr_pc),
        .instr_pop             (instr_pop),
        .bus_read_en           (bus_read_en),
        .bus_addr              (bus_addr),
        .bus_instruction_fetch (bus_instruction_fetch),
        .bus_rdata             (bus_rdata),
        .bus_ack               (bus_ack)
    );

    // Memory image: word containing address a
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (wa == 32'h0800_0200) return 32'hBBBB_AAAA;
        if (wa == 32'h0800_0204) return 32'hDDDD_CCCC;
        return {wa[15:0], wa[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq_instr.delete();
        mq_pc.delete();
        m_pend  = 1'b0;
        m_stale = 1'b0;
        m_addr  = 32'h0;
        m_fpc   = 32'h0;
        m_thumb = 1'b0;
        w_cnt   = 0;
    endtask

    // Predict the effect of the coming rising edge from the driven inputs
    task automatic model_step();
        bit          done;
        logic [31:0] w;
        logic [31:0] d;
        if (reset) begin
            model_reset();
            return;
        end
        done = m_pend && bus_ack;
        if (flush) begin
            mq_instr.delete();
            mq_pc.delete();
            m_thumb = THUMB_EN ? flush_thumb : 1'b0;
            m_fpc   = m_thumb ? (flush_pc & ~32'h1) : (flush_pc & ~32'h3);
            if (m_pend && !bus_ack) m_stale = 1'b1;
        end else begin
            if (instr_pop && mq_instr.size() > 0) begin
                void'(mq_instr.pop_front());
                void'(mq_pc.pop_front());
            end
            if (done && !m_stale) begin
                w = mem_fn(m_addr);
                d = m_thumb ? {16'h0, (m_addr[1] ? w[31:16] : w[15:0])} : w;
                mq_instr.push_back(d);
                mq_pc.push_back(m_addr);
                $display("txn fetch pc=0x%08h instr=0x%08h", m_addr, d);
                m_fpc = m_fpc + (m_thumb ? 32'd2 : 32'd4);
            end
        end
        if (done) begin
            m_pend  = 1'b0;
            m_stale = 1'b0;
        end
        if (!m_pend && mq_instr.size() < DEPTH) begin
            m_pend = 1'b1;
            m_addr = m_fpc;
        end
    endtask

    task automatic compare();
        check("bus_read_en", 32'(bus_read_en), 32'(m_pend));
        check("bus_instruction_fetch", 32'(bus_instruction_fetch), 32'(m_pend));
        if (m_pend) check("bus_addr", bus_addr, m_addr);
        check("instr_valid", 32'(instr_valid), 32'(mq_instr.size() > 0));
        if (mq_instr.size() > 0) begin
            check("instr", instr, mq_instr[0]);
            check("instr_pc", instr_pc, mq_pc[0]);
        end
    endtask

    // One clock: drive inputs (at a falling edge), predict, then compare at the next falling edge
    task automatic cycle(input bit f, input logic [31:0] fpc, input bit fth, input bit pop);
        flush       = f;
        flush_pc    = fpc;
        flush_thumb = fth;
        instr_pop   = pop;
        if (m_pend && !reset) begin
            if (w_cnt < ack_lat) begin
                bus_ack = 1'b0;
                w_cnt++;
            end else begin
                bus_ack = 1'b1;
                w_cnt   = 0;
            end
        end else begin
            bus_ack = 1'b0;
            w_cnt   = 0;
        end
        bus_rdata = bus_ack ? mem_fn(bus_addr) : 32'h0;
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        model_reset();
        @(negedge clk);
        // Reset state
        check("rst_read_en", 32'(bus_read_en), 32'h0);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        idle_cycle();
        idle_cycle();

        // T1: zero-wait fill from RESET_PC, no pops
        reset = 1'b0;
        idle_cycle();
        check("t1_addr0", bus_addr, 32'h0);
        check("t1_req0", 32'(bus_read_en), 32'h1);
        idle_cycle();
        check("t1_addr4", bus_addr, 32'h4);
        idle_cycle();
        check("t1_addr8", bus_addr, 32'h8);
        idle_cycle();
        check("t1_addrC", bus_addr, 32'hC);
        idle_cycle();
        check("t1_idle", 32'(bus_read_en), 32'h0);
        check("t1_count", 32'(mq_instr.size()), 32'd4);
        check("t1_head_pc", instr_pc, 32'h0);
        check("t1_head_instr", instr, 32'h5A3C_0F96);
        idle_cycle();

        // T2: pop once while full
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("t2_addr", bus_addr, 32'h10);
        check("t2_req", 32'(bus_read_en), 32'h1);
        check("t2_head_pc", instr_pc, 32'h4);
        check("t2_head_instr", instr, 32'h5A38_0F96);
        idle_cycle();

        // T3: flush while a slow request at 0x8 is pending
        ack_lat = 3;
        cycle(1'b1, 32'h0, 1'b0, 1'b0);
        k = 0;
        while (!(m_pend && m_addr == 32'h8 && w_cnt == 0) && k < 20) begin
            idle_cycle();
            k++;
        end
        check("t3_reach_8", 32'(k < 20), 32'h1);
        cycle(1'b1, 32'h0800_0100, 1'b0, 1'b0);
        check("t3_hold_a", bus_addr, 32'h8);
        check("t3_valid_a", 32'(instr_valid), 32'h0);
        for (int i = 0; i < 2; i++) begin
            idle_cycle();
            check("t3_hold", bus_addr, 32'h8);
            check("t3_hold_req", 32'(bus_read_en), 32'h1);
            check("t3_valid", 32'(instr_valid), 32'h0);
        end
        idle_cycle();
        check("t3_new_addr", bus_addr, 32'h0800_0100);
        check("t3_valid_end", 32'(instr_valid), 32'h0);
        ack_lat = 0;
        for (int i = 0; i < 8; i++) idle_cycle();

        // T4: flush into Thumb mode (word mode when Thumb support is absent)
        cycle(1'b1, 32'h0800_0203, 1'b1, 1'b0);
        check("t4_addr0", bus_addr, THUMB_EN ? 32'h0800_0202 : 32'h0800_0200);
        idle_cycle();
        check("t4_instr0", instr, THUMB_EN ? 32'h0000_BBBB : 32'hBBBB_AAAA);
        check("t4_pc0", instr_pc, THUMB_EN ? 32'h0800_0202 : 32'h0800_0200);
        check("t4_addr1", bus_addr, THUMB_EN ? 32'h0800_0204 : 32'h0800_0204);
        idle_cycle();
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("t4_instr1", instr, THUMB_EN ? 32'h0000_CCCC : 32'hDDDD_CCCC);
        check("t4_pc1", instr_pc, 32'h0800_0204);

        // T5: flush coinciding with bus_ack
        k = 0;
        while (!m_pend && k < 10) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            k++;
        end
        check("t5_pending", 32'(m_pend), 32'h1);
        cycle(1'b1, 32'h0000_1000, 1'b0, 1'b1);
        check("t5_addr", bus_addr, 32'h0000_1000);
        check("t5_req", 32'(bus_read_en), 32'h1);
        check("t5_dropped", 32'(instr_valid), 32'h0);
        idle_cycle();
        check("t5_head_pc", instr_pc, 32'h0000_1000);
        check("t5_next_addr", bus_addr, 32'h0000_1004);

        // Mixed traffic: varying latency, pops, flushes incl. back-to-back
        for (int i = 0; i < 60; i++) begin
            ack_lat = (i / 12) % 3;
            if (i == 20)      cycle(1'b1, 32'h0000_2002, 1'b1, 1'b1);
            else if (i == 33) cycle(1'b1, 32'h1111_1113, 1'b0, 1'b1);
            else if (i == 34) cycle(1'b1, 32'h2222_2226, 1'b1, 1'b0);
            else              cycle(1'b0, 32'h0, 1'b0, (i % 3) != 0);
        end

        // T6: asynchronous reset in the middle of a pending request
        ack_lat = 2;
        k = 0;
        while (!(m_pend && mq_instr.size() > 0) && k < 20) begin
            idle_cycle();
            k++;
        end
        check("t6_setup", 32'(k < 20), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_read_en_low", 32'(bus_read_en), 32'h0);
        check("t6_fetch_low", 32'(bus_instruction_fetch), 32'h0);
        check("t6_valid_low", 32'(instr_valid), 32'h0);
        model_reset();
        idle_cycle();
        idle_cycle();
        reset   = 1'b0;
        ack_lat = 0;
        idle_cycle();
        check("t6_restart_addr", bus_addr, 32'h0);
        check("t6_restart_req", 32'(bus_read_en), 32'h1);
        idle_cycle();
        check("t6_restart_pc", instr_pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
